// File: rtl/d_trigger_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : d_trigger_pkg
// Brief   : MODE encodings, stage next-value select and FILL width helper.
// Revision: 1.0
// ---------------------------------------------------------------------------
package d_trigger_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_CLR   = 2'b11;

  typedef enum logic [1:0] {
    SEL_SER  = 2'b00,
    SEL_PAR  = 2'b01,
    SEL_ZERO = 2'b10
  } stage_sel_e;

  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/d_trigger_pipe_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : d_trigger_pipe_if
// Brief   : Control, data and status bundle of the register pipeline.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface d_trigger_pipe_if
  import d_trigger_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int FW = fill_w(DEPTH);

  logic                   EN;
  logic [1:0]             MODE;
  logic [WIDTH-1:0]       D;
  logic [WIDTH*DEPTH-1:0] PD;
  logic [WIDTH-1:0]       Q;
  logic [WIDTH-1:0]       QR;
  logic [WIDTH*DEPTH-1:0] TAP;
  logic [FW-1:0]          FILL;
  logic                   FULL;

  modport master (
    output EN, MODE, D, PD,
    input  Q, QR, TAP, FILL, FULL
  );

  modport slave (
    input  EN, MODE, D, PD,
    output Q, QR, TAP, FILL, FULL
  );

endinterface
`default_nettype wire

// File: rtl/d_trigger_pipe_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : d_trigger_stage
// Brief   : One WIDTH-bit flop with sync reset, enable and serial/parallel/zero mux.
// Revision: 1.0
// ---------------------------------------------------------------------------
module d_trigger_stage
  import d_trigger_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             en_i,
  input  stage_sel_e            sel_i,
  input  wire logic [WIDTH-1:0] ser_i,
  input  wire logic [WIDTH-1:0] par_i,
  output logic      [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = '0;
    case (sel_i)
      SEL_SER:  data_d = ser_i;
      SEL_PAR:  data_d = par_i;
      default:  data_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= RST_VAL;
    end else if (en_i) begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/d_trigger_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : d_trigger_pipe
// Brief   : WIDTH x DEPTH register pipeline with shift/load/clear and fill count.
//           Define D_TRIGGER_PIPE_ROT_EN to turn MODE=11 into a rotate.
// Revision: 1.0
// ---------------------------------------------------------------------------
module d_trigger_pipe
  import d_trigger_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input wire logic         CP,
  input wire logic         RST,
  d_trigger_pipe_if.slave  bus
);

  localparam int            c_FW       = fill_w(DEPTH);
  localparam logic [c_FW-1:0] c_FULL_CNT = c_FW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] w_head_ser;
  logic             w_stage_en;
  stage_sel_e       w_sel;
  logic [c_FW-1:0]  fill_d;
  logic [c_FW-1:0]  fill_q;

  assign w_stage_en = bus.EN && (bus.MODE != MODE_HOLD);

`ifdef D_TRIGGER_PIPE_ROT_EN
  // Rotate reuses the serial path with the last stage wrapped into stage 0.
  assign w_head_ser = (bus.MODE == MODE_CLR) ? stage_q[DEPTH-1] : bus.D;
`else
  assign w_head_ser = bus.D;
`endif

  always_comb begin
    w_sel = SEL_SER;
    case (bus.MODE)
      MODE_LOAD: w_sel = SEL_PAR;
`ifdef D_TRIGGER_PIPE_ROT_EN
      MODE_CLR:  w_sel = SEL_SER;
`else
      MODE_CLR:  w_sel = SEL_ZERO;
`endif
      default:   w_sel = SEL_SER;
    endcase
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] w_ser;

    if (k == 0) begin : g_head
      assign w_ser = w_head_ser;
    end else begin : g_body
      assign w_ser = stage_q[k-1];
    end

    d_trigger_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk_i (CP),
      .rst_i (RST),
      .en_i  (w_stage_en),
      .sel_i (w_sel),
      .ser_i (w_ser),
      .par_i (bus.PD[k*WIDTH +: WIDTH]),
      .q_o   (stage_q[k])
    );

    assign bus.TAP[k*WIDTH +: WIDTH] = stage_q[k];
  end

  always_comb begin
    fill_d = fill_q;
    if (bus.EN) begin
      case (bus.MODE)
        MODE_SHIFT: begin
          if (fill_q != c_FULL_CNT) begin
            fill_d = fill_q + 1'b1;
          end
        end
        MODE_LOAD: fill_d = c_FULL_CNT;
`ifndef D_TRIGGER_PIPE_ROT_EN
        MODE_CLR:  fill_d = '0;
`endif
        default:   fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign bus.Q    = stage_q[DEPTH-1];
  assign bus.QR   = ~stage_q[DEPTH-1];
  assign bus.FILL = fill_q;
  assign bus.FULL = (fill_q == c_FULL_CNT);

endmodule
`default_nettype wire

// File: tb/tb_d_trigger_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_d_trigger_pipe
// Brief   : Directed self-checking bench for d_trigger_pipe (8 x 4, RST_VAL=0).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_d_trigger_pipe;
  import d_trigger_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic CP;
  logic RST;
  int   n_checks;
  int   n_fail;

  d_trigger_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  d_trigger_pipe #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (8'h00)
  ) dut (
    .CP  (CP),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; bus.EN = 1'b1; bus.MODE = MODE_LOAD;
    bus.D = 8'h5A; bus.PD = 32'hDEADBEEF;
    tick();
    tick();
    n_checks++; if (bus.Q    !== 8'h00)  begin n_fail++; $display("FAIL reset_q: got %h expected 00", bus.Q); end
    n_checks++; if (bus.QR   !== 8'hFF)  begin n_fail++; $display("FAIL reset_qr: got %h expected ff", bus.QR); end
    n_checks++; if (bus.TAP  !== 32'h0)  begin n_fail++; $display("FAIL reset_tap: got %h expected 0", bus.TAP); end
    n_checks++; if (bus.FILL !== 3'd0)   begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", bus.FILL); end
    n_checks++; if (bus.FULL !== 1'b0)   begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.FULL); end
  endtask

  task automatic test_shift();
    logic [7:0] din [4];
    din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44;
    RST = 1'b0; bus.EN = 1'b1; bus.MODE = MODE_SHIFT;
    for (int i = 0; i < 4; i++) begin
      bus.D = din[i];
      tick();
      n_checks++;
      if (bus.FILL !== 3'(i + 1)) begin
        n_fail++; $display("FAIL shift_fill_%0d: got %0d expected %0d", i, bus.FILL, i + 1);
      end
    end
    n_checks++; if (bus.Q    !== 8'h11)        begin n_fail++; $display("FAIL shift_q4: got %h expected 11", bus.Q); end
    n_checks++; if (bus.FULL !== 1'b1)         begin n_fail++; $display("FAIL shift_full4: got %b expected 1", bus.FULL); end
    n_checks++; if (bus.TAP  !== 32'h11223344) begin n_fail++; $display("FAIL shift_tap4: got %h expected 11223344", bus.TAP); end
    bus.D = 8'h55;
    tick();
    n_checks++; if (bus.Q    !== 8'h22)        begin n_fail++; $display("FAIL shift_q5: got %h expected 22", bus.Q); end
    n_checks++; if (bus.FILL !== 3'd4)         begin n_fail++; $display("FAIL shift_fill_sat: got %0d expected 4", bus.FILL); end
    n_checks++; if (bus.TAP  !== 32'h22334455) begin n_fail++; $display("FAIL shift_tap5: got %h expected 22334455", bus.TAP); end
  endtask

  task automatic test_enable_hold();
    logic [1:0] modes [3];
    modes[0] = MODE_SHIFT; modes[1] = MODE_LOAD; modes[2] = MODE_CLR;
    bus.EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.MODE = modes[i];
      bus.D    = (i % 2 == 0) ? 8'hAA : 8'h55;
      bus.PD   = 32'hCAFEF00D;
      tick();
      n_checks++;
      if (bus.TAP !== 32'h22334455 || bus.Q !== 8'h22 || bus.FILL !== 3'd4) begin
        n_fail++; $display("FAIL en_hold_%0d: got tap=%h q=%h fill=%0d expected tap=22334455 q=22 fill=4",
                           i, bus.TAP, bus.Q, bus.FILL);
      end
    end
  endtask

  task automatic test_load();
    bus.EN = 1'b1; bus.MODE = MODE_LOAD; bus.PD = 32'h44332211; bus.D = 8'h99;
    tick();
    n_checks++; if (bus.TAP  !== 32'h44332211) begin n_fail++; $display("FAIL load_tap: got %h expected 44332211", bus.TAP); end
    n_checks++; if (bus.Q    !== 8'h44)        begin n_fail++; $display("FAIL load_q: got %h expected 44", bus.Q); end
    n_checks++; if (bus.QR   !== 8'hBB)        begin n_fail++; $display("FAIL load_qr: got %h expected bb", bus.QR); end
    n_checks++; if (bus.FILL !== 3'd4)         begin n_fail++; $display("FAIL load_fill: got %0d expected 4", bus.FILL); end
    bus.MODE = MODE_HOLD; bus.PD = 32'h0; bus.D = 8'h00;
    tick();
    n_checks++;
    if (bus.TAP !== 32'h44332211 || bus.FILL !== 3'd4) begin
      n_fail++; $display("FAIL mode_hold: got tap=%h fill=%0d expected tap=44332211 fill=4", bus.TAP, bus.FILL);
    end
  endtask

  task automatic test_clear();
    bus.EN = 1'b1; bus.MODE = MODE_CLR; bus.D = 8'h77;
    tick();
`ifdef D_TRIGGER_PIPE_ROT_EN
    n_checks++; if (bus.TAP  !== 32'h33221144) begin n_fail++; $display("FAIL rot_tap: got %h expected 33221144", bus.TAP); end
    n_checks++; if (bus.Q    !== 8'h33)        begin n_fail++; $display("FAIL rot_q: got %h expected 33", bus.Q); end
    n_checks++; if (bus.FILL !== 3'd4)         begin n_fail++; $display("FAIL rot_fill: got %0d expected 4", bus.FILL); end
`else
    n_checks++; if (bus.TAP  !== 32'h0)  begin n_fail++; $display("FAIL clr_tap: got %h expected 0", bus.TAP); end
    n_checks++; if (bus.QR   !== 8'hFF)  begin n_fail++; $display("FAIL clr_qr: got %h expected ff", bus.QR); end
    n_checks++; if (bus.FILL !== 3'd0)   begin n_fail++; $display("FAIL clr_fill: got %0d expected 0", bus.FILL); end
    n_checks++; if (bus.FULL !== 1'b0)   begin n_fail++; $display("FAIL clr_full: got %b expected 0", bus.FULL); end
`endif
  endtask

  task automatic test_reset_mid();
    // Reset wins even with EN low
    RST = 1'b1; bus.EN = 1'b0; bus.MODE = MODE_SHIFT;
    tick();
    n_checks++;
    if (bus.TAP !== 32'h0 || bus.FILL !== 3'd0) begin
      n_fail++; $display("FAIL rst_en0: got tap=%h fill=%0d expected tap=0 fill=0", bus.TAP, bus.FILL);
    end
    RST = 1'b0; bus.EN = 1'b1; bus.MODE = MODE_SHIFT;
    bus.D = 8'h01; tick();
    bus.D = 8'h02; tick();
    n_checks++;
    if (bus.FILL !== 3'd2 || bus.TAP !== 32'h00000102) begin
      n_fail++; $display("FAIL mid_pre: got tap=%h fill=%0d expected tap=00000102 fill=2", bus.TAP, bus.FILL);
    end
    RST = 1'b1; bus.MODE = MODE_LOAD; bus.PD = 32'hFFFFFFFF;
    tick();
    n_checks++;
    if (bus.TAP !== 32'h0 || bus.FILL !== 3'd0 || bus.FULL !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst: got tap=%h fill=%0d full=%b expected tap=0 fill=0 full=0",
                         bus.TAP, bus.FILL, bus.FULL);
    end
    RST = 1'b0; bus.MODE = MODE_SHIFT; bus.D = 8'hA5;
    tick();
    n_checks++; if (bus.FILL !== 3'd1)         begin n_fail++; $display("FAIL post_fill: got %0d expected 1", bus.FILL); end
    n_checks++; if (bus.TAP  !== 32'h000000A5) begin n_fail++; $display("FAIL post_tap: got %h expected 000000a5", bus.TAP); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    bus.EN   = 1'b0;
    bus.MODE = MODE_HOLD;
    bus.D    = '0;
    bus.PD   = '0;
    test_reset();
    test_shift();
    test_enable_hold();
    test_load();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/d_trigger_pipe.md
Name: d_trigger_pipe

Overview:
- Parametrised successor to the single-bit D trigger: a WIDTH-bit, DEPTH-stage edge-triggered register pipeline.
- Adds clock enable, synchronous reset, parallel load, clear, fill tracking and complemented output.
- DEPTH=1 with MODE=01 and EN=1 reproduces the plain D trigger (Q follows D one edge later, QR=~Q).
- Used as a delay line, skew-alignment stage or loadable staging register in the digital-circuit library.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 4, number of stages (>=1)
- RST_VAL, 0, WIDTH-bit value loaded into every stage on reset

Ports:
- CP  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous reset, active-high
- EN  in  1  stage enable; 0 = hold everything
- MODE  in  2  operation select: 00 hold, 01 shift, 10 parallel load, 11 clear
- D  in  WIDTH  serial data into stage 0
- PD  in  WIDTH*DEPTH  parallel load data; stage k = PD[k*WIDTH +: WIDTH]
- Q  out  WIDTH  last stage (stage DEPTH-1)
- QR  out  WIDTH  bitwise complement of Q
- TAP  out  WIDTH*DEPTH  all stages, same packing as PD
- FILL  out  clog2(DEPTH+1)  number of valid stages
- FULL  out  1  FILL==DEPTH

Behaviour:
- Clock and reset: one clock, CP. Reset RST is synchronous and active-high; there is no asynchronous path.
- Priority per edge: RST > EN=0 > MODE.
- RST=1: every stage <= RST_VAL, FILL <= 0. Hence Q=RST_VAL, QR=~RST_VAL, FULL=0.
- EN=0: stages and FILL hold regardless of MODE, D or PD.
- MODE=00 (hold): no change.
- MODE=01 (shift): stage0 <= D; stage k <= stage k-1. FILL <= min(FILL+1, DEPTH), saturating with no wrap.
- MODE=10 (load): stage k <= PD slice k; FILL <= DEPTH.
- MODE=11 (clear): stages <= 0 (not RST_VAL); FILL <= 0.
- Latency: with shift every cycle, D sampled at edge n appears on Q after edge n+DEPTH-1. That is DEPTH edges inclusive, so the DEPTH=1 case is one edge, like a D trigger.
- Outputs: Q, QR, TAP, FULL are pure register or complement decode, with no combinational path from any input. FULL is registered-equivalent, decoded from FILL only.
- RST asserted mid-sequence aborts it: the next edge yields the reset state whatever EN and MODE are.
- MODE and D may change every cycle; no handshake or stall.

Optional Feature:
- Macro: D_TRIGGER_PIPE_ROT_EN.
- Defined: MODE=11 becomes rotate. stage0 <= stage DEPTH-1, stage k <= stage k-1, FILL unchanged. Clear is then available only via RST.
- Undefined: MODE=11 is clear, as above.
- Port list is identical in both builds.

Decomposition:
- Package d_trigger_pkg holds:
  - MODE encodings: MODE_HOLD=2'b00, MODE_SHIFT=2'b01, MODE_LOAD=2'b10, MODE_CLR=2'b11.
  - A FILL-width function clog2(DEPTH+1).
- Sub-module d_trigger_stage: one WIDTH-bit flop with sync reset value, enable, and 3:1 next-value mux (serial-in / parallel-in / zero). It is instantiated DEPTH times in a generate loop.
- FILL counter and FULL decode live in the top.

Test Plan (WIDTH=8, DEPTH=4, RST_VAL=0):
1. RST=1 for 2 edges with EN=1, MODE=10 -> Q=0x00, QR=0xFF, TAP=0, FILL=0, FULL=0.
2. EN=1, MODE=01, D=0x11,0x22,0x33,0x44 on consecutive edges -> FILL=1,2,3,4; after 4th edge Q=0x11, FULL=1. 5th edge with D=0x55 -> Q=0x22, FILL stays 4.
3. EN=0 for 3 edges with MODE=01 and D toggling -> TAP, Q, FILL unchanged.
4. EN=1, MODE=10, PD=0x44332211 -> next edge TAP=0x44332211, Q=0x44, QR=0xBB, FILL=4.
5. After step 4, MODE=11:
   - Without macro -> TAP=0, FILL=0, FULL=0.
   - With D_TRIGGER_PIPE_ROT_EN -> TAP=0x33221144, Q=0x33, FILL=4.
6. Mid-shift (FILL=2), assert RST with EN=1, MODE=10 for one edge -> TAP=0, FILL=0. Release and shift D=0xA5 -> FILL=1, TAP[7:0]=0xA5.
